// File: rtl/switch_debounce.sv
// switch_debounce: two-flop synchroniser plus tick-sampled per-bit debounce for the slide switches.
// Optional sticky per-bit change flags (chg_clr/chg_mask) are built only when SWDB_STICKY_EN is defined.

module swdb_bit #(
  parameter int STABLE_CNT = 4
) (
  input  logic switclk,
  input  logic switrst,
  input  logic tick,
  input  logic s2,
  output logic stable,
  output logic flip
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // Any tick that sees the old level restarts the run of differing samples.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip     = 1'b0;
    if (tick) begin
      if (s2 == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = s2;
        cnt_d    = '0;
        flip     = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge switclk) begin
    if (switrst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
endmodule

module switch_debounce #(
  parameter int WIDTH      = 16,
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CNT = 4
) (
  input  logic             switclk,
  input  logic             switrst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic             sample_tick
`ifdef SWDB_STICKY_EN
  ,
  input  logic             chg_clr,
  output logic [WIDTH-1:0] chg_mask
`endif
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] flip, stable_bits;

  always_comb begin
    s1_d      = sw_raw;
    s2_d      = s1_q;
    presc_d   = (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
    tick_d    = (presc_q == PRE_LAST);
    changed_d = |flip;
  end

  always_ff @(posedge switclk) begin
    if (switrst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      changed_q <= changed_d;
    end
  end

  // Every bit debounces independently against the shared tick.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    swdb_bit #(.STABLE_CNT(STABLE_CNT)) u_bit (
      .switclk (switclk),
      .switrst (switrst),
      .tick    (tick_q),
      .s2      (s2_q[i]),
      .stable  (stable_bits[i]),
      .flip    (flip[i])
    );
  end

  assign sw_stable   = stable_bits;
  assign sw_changed  = changed_q;
  assign sample_tick = tick_q;

`ifdef SWDB_STICKY_EN
  logic [WIDTH-1:0] chg_mask_q, chg_mask_d;

  // A bit flipping in the clear cycle keeps its flag; all others drop.
  always_comb chg_mask_d = chg_clr ? flip : (chg_mask_q | flip);

  always_ff @(posedge switclk) begin
    if (switrst) chg_mask_q <= '0;
    else         chg_mask_q <= chg_mask_d;
  end

  assign chg_mask = chg_mask_q;
`endif
endmodule

// File: tb/tb_switch_debounce.sv
// Randomised + directed bench for switch_debounce: a tick-level reference model predicts
// sw_stable updates into a queue, and a negedge monitor pops/compares on each sw_changed pulse.
module tb_switch_debounce;
  localparam int W  = 16;
  localparam int TD = 4;
  localparam int SC = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw = '0;
  logic [W-1:0] stable;
  logic         changed, tick;
`ifdef SWDB_STICKY_EN
  logic         clr = 1'b0;
  logic [W-1:0] mask;
`endif

  always #5 clk = ~clk;

  switch_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .switclk     (clk),
    .switrst     (rst),
    .sw_raw      (raw),
    .sw_stable   (stable),
    .sw_changed  (changed),
    .sample_tick (tick)
`ifdef SWDB_STICKY_EN
    ,
    .chg_clr     (clr),
    .chg_mask    (mask)
`endif
  );

  int total = 0;
  int pass  = 0;

  // Reference model: tick-sample windows since the last accepted level.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_mask = '0;
  logic         m_tick = 1'b0;
  int           n = 0;
  bit           win [W][SC];
  int           nvalid [W];
  logic [W-1:0] exp_q [$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Newest-first count of consecutive samples that differ from the accepted level.
  function automatic int run_len(int i);
    int r = 0;
    for (int k = 0; k < nvalid[i]; k++) begin
      if (win[i][k] != m_stable[i]) r++;
      else break;
    end
    return r;
  endfunction

  task automatic model_edge();
    logic [W-1:0] flips = '0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_tick = 1'b0; n = 0;
      for (int i = 0; i < W; i++) nvalid[i] = 0;
    end else begin
      if (m_tick) begin
        for (int i = 0; i < W; i++) begin
          for (int k = SC - 1; k > 0; k--) win[i][k] = win[i][k-1];
          win[i][0] = m_s2[i];
          if (nvalid[i] < SC) nvalid[i]++;
          if (run_len(i) >= SC) begin
            flips[i]    = 1'b1;
            m_stable[i] = ~m_stable[i];
            nvalid[i]   = 0;
          end
        end
      end
`ifdef SWDB_STICKY_EN
      m_mask = clr ? flips : (m_mask | flips);
`endif
      if (flips != '0) exp_q.push_back(m_stable);
      n++;
      m_tick = (n % TD == 0);
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic cyc(input int k = 1);
    for (int j = 0; j < k; j++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  // Monitor: per-cycle level checks plus scoreboard pop on each change pulse.
  always @(negedge clk) begin
    logic [W-1:0] e;
    chk("sw_stable", stable, m_stable);
    chk("sample_tick", W'(tick), W'(m_tick));
`ifdef SWDB_STICKY_EN
    chk("chg_mask", mask, m_mask);
`endif
    if (changed === 1'b1 || exp_q.size() != 0) begin
      total++;
      if (changed === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (stable === e) pass++;
        else $display("FAIL pulse_value: got %h expected %h at %0t", stable, e, $time);
      end else begin
        $display("FAIL sw_changed: got %b expected %b at %0t", changed, exp_q.size() != 0, $time);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int den;
    for (int i = 0; i < W; i++) nvalid[i] = 0;

    // 1: release reset with all switches high
    raw = 16'hFFFF; rst = 1'b1;
    cyc(3);
    chk("reset_stable", stable, 16'h0000);
    chk("reset_changed", W'(changed), W'(0));
    rst = 1'b0;
    cyc(12);
    chk("t1_before_3rd_tick", stable, 16'h0000);
    cyc(1);
    chk("t1_after_3rd_tick", stable, 16'hFFFF);
    chk("t1_pulse", W'(changed), W'(1));
    cyc(4);

    // 2: short bounce on bit 3 (from 0)
    raw = 16'hFFF7; cyc(20);
    raw = 16'hFFFF; cyc(8);
    raw = 16'hFFF7; cyc(20);
    chk("t2_bit3_settled_low", W'(stable[3]), W'(0));
    raw[3] = 1'b1; cyc(8);
    raw[3] = 1'b0; cyc(20);
    chk("t2_bit3_stays_low", W'(stable[3]), W'(0));

    // 3: bit 5 chatter then hold high
    raw = 16'h0000; cyc(20);
    for (int j = 0; j < 20; j++) begin
      if (j % 3 == 0) raw[5] = ~raw[5];
      cyc(1);
    end
    raw[5] = 1'b1; cyc(20);
    chk("t3_bit5_high", W'(stable[5]), W'(1));

    // 4: bits 0 and 15 together
    raw = raw ^ 16'h8001; cyc(20);
    chk("t4_bits_0_15", stable & 16'h8001, 16'h8001);

    // 5: reset after 2 of 3 qualifying ticks on bit 7
    raw = 16'h0000; cyc(20);
    raw[7] = 1'b1;
    for (int j = 0; j < 40 && run_len(7) < 2; j++) cyc(1);
    chk("t5_two_ticks_seen", W'(run_len(7)), W'(2));
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc(12);
    chk("t5_bit7_still_low", stable, 16'h0000);
    cyc(1);
    chk("t5_bit7_after_fresh", stable, 16'h0080);
    cyc(4);

`ifdef SWDB_STICKY_EN
    // 6: sticky flags with clear coinciding with a flip
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("t6_cleared", mask, 16'h0000);
    raw[1] = 1'b1; cyc(20);
    raw[2] = 1'b1; cyc(20);
    raw[4] = 1'b1;
    for (int j = 0; j < 40 && !(m_tick && m_s2[4] != m_stable[4] && run_len(4) == SC - 1); j++) cyc(1);
    chk("t6_before_clear", mask, 16'h0006);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("t6_after_clear", mask, 16'h0010);
    cyc(4);
`endif

    // Random phase: bursts of bouncing at varying rates, occasional resets.
    for (int blk = 0; blk < 30; blk++) begin
      case ($urandom_range(0, 2))
        0: den = 4;
        1: den = 20;
        default: den = 60;
      endcase
      for (int j = 0; j < 100; j++) begin
        for (int b = 0; b < W; b++)
          if ($urandom_range(0, den - 1) == 0) raw[b] = ~raw[b];
        rst = ($urandom_range(0, 599) == 0);
`ifdef SWDB_STICKY_EN
        clr = ($urandom_range(0, 29) == 0);
`endif
        cyc(1);
      end
    end
    rst = 1'b0;
`ifdef SWDB_STICKY_EN
    clr = 1'b0;
`endif
    cyc(30);
    chk("drain_queue_empty", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
